vram_rect_fill: RTL and testbench

- Upstream writer for the VRAM frame buffer.
- Accepts rectangle-fill commands (corner coordinates plus 12-bit RGB colour) over a valid/ready handshake.
- Streams one pixel write per cycle into the VRAM write port.
- The VGA controller keeps reading the same VRAM independently on its own read port.

---
 rtl/vram_rect_fill.sv | 158 +++++++++++++++
 tb/tb_vram_rect_fill.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_rect_fill.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vram_rect_fill                                                |
// | Purpose  : Rectangle-fill engine feeding the VRAM write port. Accepts a  |
// |            corner/colour command, clips it to the visible area, rejects |
// |            empty or off-screen rectangles and streams one pixel write    |
// |            per cycle in raster order.                                    |
// | Options  : VRAM_RECT_FILL_VBLANK_ONLY_EN - write only while vblank=1.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vram_rect_fill #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9,
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [COL_W-1:0] cmd_x0,
    input  logic [ROW_W-1:0] cmd_y0,
    input  logic [COL_W-1:0] cmd_x1,
    input  logic [ROW_W-1:0] cmd_y1,
    input  logic [PIX_W-1:0] cmd_color,
    input  logic             vblank,
    output logic             wr_en,
    output logic [COL_W-1:0] wr_col,
    output logic [ROW_W-1:0] wr_row,
    output logic [PIX_W-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [COL_W-1:0] C_COL_MAX = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0] C_ROW_MAX = ROW_W'(V_RES - 1);

    state_t           r_state;
    state_t           w_state_n;
    logic [COL_W-1:0] r_x0;
    logic [COL_W-1:0] r_x1c;
    logic [ROW_W-1:0] r_y1c;
    logic [COL_W-1:0] w_x1c;
    logic [ROW_W-1:0] w_y1c;
    logic             w_reject;
    logic             w_xfer;
    logic             w_accept;
    logic             w_write;
    logic             w_last;
    logic             w_slot;

    // Write slot: every FILL cycle, or only during blanking when enabled
`ifdef VRAM_RECT_FILL_VBLANK_ONLY_EN
    assign w_slot = vblank;
`else
    logic w_vblank_unused;
    assign w_vblank_unused = vblank;
    assign w_slot          = 1'b1;
`endif

    // Clip the far corner to the screen and decide whether the command is empty
    always_comb begin
        w_x1c    = (cmd_x1 > C_COL_MAX) ? C_COL_MAX : cmd_x1;
        w_y1c    = (cmd_y1 > C_ROW_MAX) ? C_ROW_MAX : cmd_y1;
        w_reject = (32'(cmd_x0) >= 32'(H_RES)) || (32'(cmd_y0) >= 32'(V_RES)) ||
                   (cmd_x0 > w_x1c) || (cmd_y0 > w_y1c);
    end

    // Final pixel of the rectangle is the bottom-right corner
    assign w_last = (wr_col == r_x1c) && (wr_row == r_y1c);
    assign wr_en  = w_write;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state and handshake/status decode
    always_comb begin
        w_state_n = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        w_write   = 1'b0;
        w_xfer    = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                w_xfer    = cmd_valid;
                w_accept  = cmd_valid && !w_reject;
                if (w_accept) begin
                    w_state_n = S_FILL;
                end
            end
            S_FILL: begin
                busy    = 1'b1;
                w_write = w_slot;
                if (w_slot && w_last) begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Command latch, raster address counters and reject pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x0    <= '0;
            r_x1c   <= '0;
            r_y1c   <= '0;
            wr_col  <= '0;
            wr_row  <= '0;
            wr_data <= '0;
            err     <= 1'b0;
        end else begin
            err <= w_xfer && w_reject;
            if (w_accept) begin
                r_x0    <= cmd_x0;
                r_x1c   <= w_x1c;
                r_y1c   <= w_y1c;
                wr_col  <= cmd_x0;
                wr_row  <= cmd_y0;
                wr_data <= cmd_color;
            end else if (w_write && !w_last) begin
                // Counters stop on the last pixel so they never pass the clip limits
                if (wr_col == r_x1c) begin
                    wr_col <= r_x0;
                    wr_row <= wr_row + ROW_W'(1);
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_rect_fill.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vram_rect_fill                                             |
// | Purpose  : Self-checking bench for vram_rect_fill (table + scoreboard).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vram_rect_fill;

`ifdef VRAM_RECT_FILL_VBLANK_ONLY_EN
    localparam logic VB_DEF = 1'b1;
`else
    localparam logic VB_DEF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0;
    logic [8:0]  cmd_y0 = '0;
    logic [9:0]  cmd_x1 = '0;
    logic [8:0]  cmd_y1 = '0;
    logic [11:0] cmd_color = '0;
    logic        vblank = VB_DEF;
    logic        wr_en;
    logic [9:0]  wr_col;
    logic [8:0]  wr_row;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    vram_rect_fill dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .vblank(vblank), .wr_en(wr_en), .wr_col(wr_col),
        .wr_row(wr_row), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x0;
        logic [8:0]  y0;
        logic [9:0]  x1;
        logic [8:0]  y1;
        logic [11:0] color;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    vec_t        vecs[10];
    logic [30:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          wr_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (rstn && wr_en === 1'b1) begin
            wr_count++;
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {1'b0, wr_col, wr_row, wr_data}, 32'h7fffffff);
            end else begin
                chk("write", {1'b0, wr_col, wr_row, wr_data}, {1'b0, sb_q.pop_front()});
            end
        end
    end

    // Model: clip and push the raster-ordered pixel list
    task automatic push_rect(input vec_t v);
        int xc, yc;
        xc = (int'(v.x1) > 639) ? 639 : int'(v.x1);
        yc = (int'(v.y1) > 479) ? 479 : int'(v.y1);
        for (int r = int'(v.y0); r <= yc; r++)
            for (int c = int'(v.x0); c <= xc; c++)
                sb_q.push_back({10'(c), 9'(r), v.color});
    endtask

    task automatic drive(input vec_t v);
        cmd_x0 = v.x0; cmd_y0 = v.y0; cmd_x1 = v.x1; cmd_y1 = v.y1; cmd_color = v.color;
    endtask

    task automatic send(input vec_t v, input string tag);
        int  start;
        int  cyc;
        bit  seen;
        if (!v.exp_err) push_rect(v);
        start = wr_count;
        @(negedge clk);
        drive(v);
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
        chk({tag, "_ready_wait"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x0 = 10'($urandom); cmd_y0 = 9'($urandom);
        cmd_x1 = 10'($urandom); cmd_y1 = 9'($urandom); cmd_color = 12'($urandom);
        seen = 1'b0;
        for (cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk({tag, "_busy1"}, 32'(busy), 32'(!v.exp_err));
                chk({tag, "_ready1"}, 32'(cmd_ready), 32'(v.exp_err));
            end
            if (err || done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_terminated"}, 32'(seen), 32'd1);
        if (v.exp_err) begin
            chk({tag, "_err_cycle"}, 32'(cyc), 32'd1);
            chk({tag, "_err_nodone"}, 32'(done), 32'd0);
        end else begin
            chk({tag, "_done_cycle"}, 32'(cyc), 32'(v.exp_writes + 1));
            chk({tag, "_done_wren"}, 32'(wr_en), 32'd0);
        end
        chk({tag, "_writes"}, 32'(wr_count - start), 32'(v.exp_writes));
        @(negedge clk);
        chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_pulse_after"}, {30'd0, done, err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{10'd5,   9'd3,   10'd6,   9'd4,   12'hF00, 1'b0, 4};
        vecs[1] = '{10'd638, 9'd478, 10'd700, 9'd500, 12'h0AB, 1'b0, 4};
        vecs[2] = '{10'd10,  9'd0,   10'd9,   9'd0,   12'h123, 1'b1, 0};
        vecs[3] = '{10'd640, 9'd0,   10'd650, 9'd0,   12'h456, 1'b1, 0};
        vecs[4] = '{10'd0,   9'd0,   10'd0,   9'd0,   12'hFFF, 1'b0, 1};
        vecs[5] = '{10'd0,   9'd1,   10'd2,   9'd1,   12'h0F0, 1'b0, 3};
        vecs[6] = '{10'd100, 9'd200, 10'd100, 9'd203, 12'h00F, 1'b0, 4};
        vecs[7] = '{10'd600, 9'd479, 10'd1023, 9'd479, 12'hA5A, 1'b0, 40};
        vecs[8] = '{10'd0,   9'd480, 10'd5,   9'd490, 12'h111, 1'b1, 0};
        vecs[9] = '{10'd3,   9'd5,   10'd4,   9'd4,   12'h222, 1'b1, 0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_flags", {28'd0, wr_en, busy, done, err}, 32'd0);
        chk("rst_addr", {1'b0, wr_col, wr_row, wr_data}, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) send(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back with cmd_valid held high
        v = '{10'd0, 9'd0, 10'd0, 9'd0, 12'h000, 1'b0, 1};
        push_rect(v);
        v = '{10'd0, 9'd1, 10'd2, 9'd1, 12'h0F0, 1'b0, 3};
        push_rect(v);
        @(negedge clk);
        cmd_x0 = 10'd0; cmd_y0 = 9'd0; cmd_x1 = 10'd0; cmd_y1 = 9'd0; cmd_color = 12'h000;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk); chk("b2b_c1_wren", 32'(wr_en), 32'd1);
        @(negedge clk); chk("b2b_c2_done", 32'(done), 32'd1);
        chk("b2b_c2_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk); chk("b2b_c3_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        begin
            int c;
            for (c = 1; c <= 50; c++) begin
                @(negedge clk);
                if (done) break;
            end
            chk("b2b_second_done_cycle", 32'(c), 32'd4);
        end

        // Reset dropped during the third write of a 4x4 fill
        sb_q.push_back({10'd20, 9'd20, 12'hC3C});
        sb_q.push_back({10'd21, 9'd20, 12'hC3C});
        sb_q.push_back({10'd22, 9'd20, 12'hC3C});
        @(negedge clk);
        cmd_x0 = 10'd20; cmd_y0 = 9'd20; cmd_x1 = 10'd23; cmd_y1 = 9'd23; cmd_color = 12'hC3C;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("rstmid_flags", {29'd0, wr_en, busy, done}, 32'd0);
        chk("rstmid_ready", 32'(cmd_ready), 32'd1);
        chk("rstmid_addr", {1'b0, wr_col, wr_row, wr_data}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_nodone", 32'(done), 32'd0);
        end
        rstn = 1'b1;
        chk("rstmid_partial", 32'(sb_q.size()), 32'd0);
        send(vecs[0], "post_rst");

`ifdef VRAM_RECT_FILL_VBLANK_ONLY_EN
        // Writes only during blanking: vblank 0,1,0,0,1 over cycles 1..5
        begin
            logic [4:0] pat;
            pat = 5'b10010;
            sb_q.push_back({10'd7, 9'd9, 12'h5A5});
            sb_q.push_back({10'd8, 9'd9, 12'h5A5});
            @(negedge clk);
            cmd_x0 = 10'd7; cmd_y0 = 9'd9; cmd_x1 = 10'd8; cmd_y1 = 9'd9; cmd_color = 12'h5A5;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            vblank = pat[0];
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk($sformatf("vb_wren_c%0d", k + 1), 32'(wr_en), 32'(pat[k]));
                chk($sformatf("vb_nodone_c%0d", k + 1), 32'(done), 32'd0);
                @(posedge clk);
                #1;
                vblank = (k < 4) ? pat[k+1] : 1'b1;
            end
            @(negedge clk);
            chk("vb_done", 32'(done), 32'd1);
            @(negedge clk);
            chk("vb_ready", 32'(cmd_ready), 32'd1);
        end
`endif

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
